pipelined_adder: RTL and testbench

Parametrised, pipelined successor to the 8-bit ripple-carry adder: computes `A + B + Cin` or `A - B` over `WIDTH` bits, split into `STAGES` equal carry-chained chunks with one register stage per chunk. Operands and results move over a valid/ready handshake, so the block can sit between streaming datapath units and absorb downstream backpressure. It is the standard adder for wide datapaths where a single ripple chain cannot close timing.

---
 rtl/adder_pkg.sv | 11 +
 rtl/pipelined_adder_if.sv | 37 +++
 rtl/adder_chunk.sv | 16 +
 rtl/pipelined_adder.sv | 116 +++++++++++
 tb/tb_pipelined_adder.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_pkg.sv
// Shared defaults and parameter legality check for the pipelined adder.
package adder_pkg;

  localparam int unsigned ADDER_DEFAULT_WIDTH  = 32;
  localparam int unsigned ADDER_DEFAULT_STAGES = 4;

  function automatic bit adder_params_ok(input int unsigned width, input int unsigned stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// Operand/result stream bundle for pipelined_adder.
// io_Overflow exists only when PIPELINED_ADDER_OVERFLOW_EN is defined.
interface pipelined_adder_if import adder_pkg::*; #(
  parameter int unsigned WIDTH = ADDER_DEFAULT_WIDTH
);
  logic             io_in_valid;
  logic             io_in_ready;
  logic [WIDTH-1:0] io_A;
  logic [WIDTH-1:0] io_B;
  logic             io_Cin;
  logic             io_Sub;
  logic             io_out_valid;
  logic             io_out_ready;
  logic [WIDTH-1:0] io_Sum;
  logic             io_Cout;
`ifdef PIPELINED_ADDER_OVERFLOW_EN
  logic             io_Overflow;

  modport slave (
    input  io_in_valid, io_A, io_B, io_Cin, io_Sub, io_out_ready,
    output io_in_ready, io_out_valid, io_Sum, io_Cout, io_Overflow
  );
  modport master (
    output io_in_valid, io_A, io_B, io_Cin, io_Sub, io_out_ready,
    input  io_in_ready, io_out_valid, io_Sum, io_Cout, io_Overflow
  );
`else
  modport slave (
    input  io_in_valid, io_A, io_B, io_Cin, io_Sub, io_out_ready,
    output io_in_ready, io_out_valid, io_Sum, io_Cout
  );
  modport master (
    output io_in_valid, io_A, io_B, io_Cin, io_Sub, io_out_ready,
    input  io_in_ready, io_out_valid, io_Sum, io_Cout
  );
`endif
endinterface

// File: rtl/adder_chunk.sv
// Combinational CW-bit adder slice with carry-in and carry-out.
module adder_chunk #(
  parameter int unsigned CW = 8
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          cin,
  output logic [CW-1:0] sum,
  output logic          cout
);

  always_comb begin
    {cout, sum} = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, cin};
  end

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit add/subtract split into STAGES carry-chained registered chunks,
// valid/ready stream with global stall. Optional PIPELINED_ADDER_OVERFLOW_EN.
module pipelined_adder import adder_pkg::*; #(
  parameter int unsigned WIDTH  = ADDER_DEFAULT_WIDTH,
  parameter int unsigned STAGES = ADDER_DEFAULT_STAGES
) (
  input logic              clock,
  input logic              reset,
  pipelined_adder_if.slave bus
);

  localparam int unsigned CW = WIDTH / STAGES;

  if (!adder_params_ok(WIDTH, STAGES)) begin : g_bad_params
    $error("pipelined_adder: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
  end

  logic [STAGES-1:0]            valid_q, valid_d, carry_q, carry_d;
  logic [STAGES-1:0][WIDTH-1:0] sum_q, sum_d, a_q, a_d, b_q, b_d;
  logic [STAGES-1:0][WIDTH-1:0] a_in, b_in, s_in;
  logic [STAGES-1:0]            c_in, v_in;
  logic [STAGES-1:0][CW-1:0]    chunk_sum;
  logic [STAGES-1:0]            chunk_cout;
  logic                         advance;
`ifdef PIPELINED_ADDER_OVERFLOW_EN
  logic                         ovf_q, ovf_d;
`endif

  assign advance = !valid_q[STAGES-1] || bus.io_out_ready;

  // Stage k consumes operands from stage k-1's registers; stage 0 from the bus.
  always_comb begin
    a_in[0] = bus.io_A;
    b_in[0] = bus.io_Sub ? ~bus.io_B : bus.io_B;
    c_in[0] = bus.io_Sub ? 1'b1 : bus.io_Cin;
    s_in[0] = '0;
    v_in[0] = bus.io_in_valid;
    for (int unsigned k = 1; k < STAGES; k++) begin
      a_in[k] = a_q[k-1];
      b_in[k] = b_q[k-1];
      c_in[k] = carry_q[k-1];
      s_in[k] = sum_q[k-1];
      v_in[k] = valid_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    adder_chunk #(.CW(CW)) u_chunk (
      .a    (a_in[k][k*CW +: CW]),
      .b    (b_in[k][k*CW +: CW]),
      .cin  (c_in[k]),
      .sum  (chunk_sum[k]),
      .cout (chunk_cout[k])
    );
  end

  always_comb begin
    valid_d = valid_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    a_d     = a_q;
    b_d     = b_q;
`ifdef PIPELINED_ADDER_OVERFLOW_EN
    ovf_d   = ovf_q;
`endif
    if (advance) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        valid_d[k]             = v_in[k];
        carry_d[k]             = chunk_cout[k];
        a_d[k]                 = a_in[k];
        b_d[k]                 = b_in[k];
        sum_d[k]               = s_in[k];
        sum_d[k][k*CW +: CW]   = chunk_sum[k];
      end
`ifdef PIPELINED_ADDER_OVERFLOW_EN
      ovf_d = (a_in[STAGES-1][WIDTH-1] == b_in[STAGES-1][WIDTH-1]) &&
              (chunk_sum[STAGES-1][CW-1] != a_in[STAGES-1][WIDTH-1]);
`endif
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      carry_q <= '0;
      sum_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
`ifdef PIPELINED_ADDER_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      a_q     <= a_d;
      b_q     <= b_d;
`ifdef PIPELINED_ADDER_OVERFLOW_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Last stage's operand copies have no downstream consumer; synthesis prunes them.
  logic unused_last_ops;
  assign unused_last_ops = ^{a_q[STAGES-1], b_q[STAGES-1]};

  assign bus.io_in_ready  = advance;
  assign bus.io_out_valid = valid_q[STAGES-1];
  assign bus.io_Sum       = sum_q[STAGES-1];
  assign bus.io_Cout      = carry_q[STAGES-1];
`ifdef PIPELINED_ADDER_OVERFLOW_EN
  assign bus.io_Overflow  = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed self-checking bench for pipelined_adder (WIDTH=32, STAGES=4).
module tb_pipelined_adder;

  localparam int LAT = 4;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] sum;
    logic        cout;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   nvec  = 0;
  int   nfail = 0;

  pipelined_adder_if #(.WIDTH(32)) bus ();

  pipelined_adder #(.WIDTH(32), .STAGES(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  function automatic logic [32:0] ref_op(input logic [31:0] a, input logic [31:0] b,
                                         input logic cin, input logic sub);
    logic [31:0] be;
    logic        ce;
    be = sub ? ~b : b;
    ce = sub ? 1'b1 : cin;
    return {1'b0, a} + {1'b0, be} + {32'd0, ce};
  endfunction

  task automatic drive_beat(input logic [31:0] a, input logic [31:0] b,
                            input logic cin, input logic sub);
    bus.io_A = a; bus.io_B = b; bus.io_Cin = cin; bus.io_Sub = sub;
    bus.io_in_valid = 1'b1;
  endtask

  task automatic run_one(input logic [31:0] a, input logic [31:0] b, input logic cin,
                         input logic sub, output logic [31:0] sum, output logic cout,
                         output logic ovf, output int lat);
    @(negedge clock);
    bus.io_out_ready = 1'b1;
    drive_beat(a, b, cin, sub);
    @(negedge clock);
    bus.io_in_valid = 1'b0;
    lat = 1;
    while (bus.io_out_valid !== 1'b1 && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    sum  = bus.io_Sum;
    cout = bus.io_Cout;
`ifdef PIPELINED_ADDER_OVERFLOW_EN
    ovf  = bus.io_Overflow;
`else
    ovf  = 1'b0;
`endif
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.io_out_ready = 1'b0;
    bus.io_in_valid  = 1'b1;
    bus.io_A = 32'hFFFF_FFFF; bus.io_B = 32'h1; bus.io_Cin = 1'b1; bus.io_Sub = 1'b0;
    repeat (3) @(negedge clock);
    nvec++; if (bus.io_out_valid !== 1'b0) begin nfail++; $display("FAIL reset_out_valid got=%b exp=0", bus.io_out_valid); end
    nvec++; if (bus.io_Sum !== 32'h0) begin nfail++; $display("FAIL reset_sum got=%h exp=00000000", bus.io_Sum); end
    nvec++; if (bus.io_Cout !== 1'b0) begin nfail++; $display("FAIL reset_cout got=%b exp=0", bus.io_Cout); end
    nvec++; if (bus.io_in_ready !== 1'b1) begin nfail++; $display("FAIL reset_in_ready got=%b exp=1", bus.io_in_ready); end
`ifdef PIPELINED_ADDER_OVERFLOW_EN
    nvec++; if (bus.io_Overflow !== 1'b0) begin nfail++; $display("FAIL reset_ovf got=%b exp=0", bus.io_Overflow); end
`endif
    bus.io_in_valid  = 1'b0;
    bus.io_out_ready = 1'b1;
    reset = 1'b1;
  endtask

  task automatic test_add();
    vec_t v [5];
    logic [31:0] s; logic c, o; int lat;
    v = '{'{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1},
          '{32'h00FF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0100_0000, 1'b0},
          '{32'h1234_5678, 32'h8765_4321, 1'b0, 1'b0, 32'h9999_9999, 1'b0},
          '{32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b1},
          '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1}};
    for (int i = 0; i < 5; i++) begin
      run_one(v[i].a, v[i].b, v[i].cin, v[i].sub, s, c, o, lat);
      nvec++; if (lat != LAT) begin nfail++; $display("FAIL add_latency[%0d] got=%0d exp=%0d", i, lat, LAT); end
      nvec++; if (s !== v[i].sum) begin nfail++; $display("FAIL add_sum[%0d] got=%h exp=%h", i, s, v[i].sum); end
      nvec++; if (c !== v[i].cout) begin nfail++; $display("FAIL add_cout[%0d] got=%b exp=%b", i, c, v[i].cout); end
    end
  endtask

  task automatic test_sub();
    vec_t v [5];
    logic [31:0] s; logic c, o; int lat;
    v = '{'{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0},
          '{32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1},
          '{32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0002, 1'b1},
          '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1},
          '{32'h0001_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h0000_FFFF, 1'b1}};
    for (int i = 0; i < 5; i++) begin
      run_one(v[i].a, v[i].b, v[i].cin, v[i].sub, s, c, o, lat);
      nvec++; if (lat != LAT) begin nfail++; $display("FAIL sub_latency[%0d] got=%0d exp=%0d", i, lat, LAT); end
      nvec++; if (s !== v[i].sum) begin nfail++; $display("FAIL sub_sum[%0d] got=%h exp=%h", i, s, v[i].sum); end
      nvec++; if (c !== v[i].cout) begin nfail++; $display("FAIL sub_cout[%0d] got=%b exp=%b", i, c, v[i].cout); end
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 12;
    logic [31:0] ta [N], tb [N];
    logic        tc [N], ts [N];
    logic [32:0] ex [N];
    for (int i = 0; i < N; i++) begin
      ta[i] = 32'h89AB_CDEF ^ (32'h1357_9BDF * i);
      tb[i] = 32'h7654_3210 + (32'h0F0F_0F0F * i);
      tc[i] = i[0];
      ts[i] = (i % 3 == 2);
      ex[i] = ref_op(ta[i], tb[i], tc[i], ts[i]);
    end
    bus.io_out_ready = 1'b1;
    for (int t = 0; t <= N + LAT; t++) begin
      @(negedge clock);
      nvec++;
      if (bus.io_out_valid !== (t >= LAT && t < N + LAT)) begin
        nfail++; $display("FAIL b2b_valid[t=%0d] got=%b exp=%b", t, bus.io_out_valid, (t >= LAT && t < N + LAT));
      end
      if (t >= LAT && t < N + LAT) begin
        nvec++; if (bus.io_Sum !== ex[t-LAT][31:0]) begin nfail++; $display("FAIL b2b_sum[%0d] got=%h exp=%h", t-LAT, bus.io_Sum, ex[t-LAT][31:0]); end
        nvec++; if (bus.io_Cout !== ex[t-LAT][32]) begin nfail++; $display("FAIL b2b_cout[%0d] got=%b exp=%b", t-LAT, bus.io_Cout, ex[t-LAT][32]); end
      end
      nvec++; if (bus.io_in_ready !== 1'b1) begin nfail++; $display("FAIL b2b_in_ready[t=%0d] got=%b exp=1", t, bus.io_in_ready); end
      if (t < N) drive_beat(ta[t], tb[t], tc[t], ts[t]);
      else bus.io_in_valid = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    localparam int N = 10;
    logic [32:0] q [$];
    logic [31:0] held_sum;
    logic        held_cout;
    logic [31:0] a, b;
    logic [32:0] f;
    int sent = 0, got = 0, t = 0;
    held_sum = '0; held_cout = 1'b0;
    while (got < N && t < 60) begin
      @(negedge clock);
      bus.io_out_ready = !(t >= 7 && t < 10);
      #1;
      if (t >= 7 && t < 10) begin
        nvec++; if (bus.io_out_valid !== 1'b1) begin nfail++; $display("FAIL bp_stall_valid[t=%0d] got=%b exp=1", t, bus.io_out_valid); end
        nvec++; if (bus.io_in_ready !== 1'b0) begin nfail++; $display("FAIL bp_in_ready[t=%0d] got=%b exp=0", t, bus.io_in_ready); end
        if (t == 7) begin
          held_sum = bus.io_Sum; held_cout = bus.io_Cout;
        end else begin
          nvec++; if (bus.io_Sum !== held_sum) begin nfail++; $display("FAIL bp_sum_hold[t=%0d] got=%h exp=%h", t, bus.io_Sum, held_sum); end
          nvec++; if (bus.io_Cout !== held_cout) begin nfail++; $display("FAIL bp_cout_hold[t=%0d] got=%b exp=%b", t, bus.io_Cout, held_cout); end
        end
      end
      if (bus.io_out_valid === 1'b1 && bus.io_out_ready) begin
        nvec++;
        if (q.size() == 0) begin
          nfail++; $display("FAIL bp_extra_result got=%h exp=none", bus.io_Sum);
        end else begin
          f = q.pop_front();
          if ({bus.io_Cout, bus.io_Sum} !== f) begin
            nfail++; $display("FAIL bp_result[%0d] got=%b_%h exp=%b_%h", got, bus.io_Cout, bus.io_Sum, f[32], f[31:0]);
          end
        end
        got++;
      end
      if (sent < N) begin
        if (bus.io_in_ready === 1'b1) begin
          a = 32'h1000_0001 * (sent + 1);
          b = 32'hF0F0_0F0F - sent;
          drive_beat(a, b, sent[0], 1'b0);
          q.push_back(ref_op(a, b, sent[0], 1'b0));
          sent++;
        end else begin
          drive_beat(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 1'b0);
        end
      end else begin
        bus.io_in_valid = 1'b0;
      end
      t++;
    end
    nvec++; if (got != N) begin nfail++; $display("FAIL bp_count got=%0d exp=%0d", got, N); end
    repeat (3) @(negedge clock);
    nvec++; if (bus.io_out_valid !== 1'b0) begin nfail++; $display("FAIL bp_drain_valid got=%b exp=0", bus.io_out_valid); end
    nvec++; if (q.size() != 0) begin nfail++; $display("FAIL bp_queue_left got=%0d exp=0", q.size()); end
  endtask

`ifdef PIPELINED_ADDER_OVERFLOW_EN
  task automatic test_overflow();
    vec_t v [5];
    logic        eo [5];
    logic [31:0] s; logic c, o; int lat;
    v = '{'{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0},
          '{32'h7FFF_FFFF, 32'h0000_0000, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b0},
          '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1},
          '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1},
          '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0}};
    eo = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      run_one(v[i].a, v[i].b, v[i].cin, v[i].sub, s, c, o, lat);
      nvec++; if (s !== v[i].sum) begin nfail++; $display("FAIL ovf_sum[%0d] got=%h exp=%h", i, s, v[i].sum); end
      nvec++; if (o !== eo[i]) begin nfail++; $display("FAIL ovf_flag[%0d] got=%b exp=%b", i, o, eo[i]); end
    end
  endtask
`endif

  task automatic test_reset_midstream();
    logic [31:0] s; logic c, o; int lat, stale;
    bus.io_out_ready = 1'b1;
    for (int t = 0; t < 6; t++) begin
      @(negedge clock);
      drive_beat(32'h0100_0000 * (t + 1), 32'h0000_0011, 1'b0, 1'b0);
    end
    nvec++; if (bus.io_out_valid !== 1'b1) begin nfail++; $display("FAIL rst_mid_pre_valid got=%b exp=1", bus.io_out_valid); end
    #2 reset = 1'b0;
    #1;
    nvec++; if (bus.io_out_valid !== 1'b0) begin nfail++; $display("FAIL rst_mid_valid got=%b exp=0", bus.io_out_valid); end
    nvec++; if (bus.io_Sum !== 32'h0) begin nfail++; $display("FAIL rst_mid_sum got=%h exp=00000000", bus.io_Sum); end
    nvec++; if (bus.io_in_ready !== 1'b1) begin nfail++; $display("FAIL rst_mid_in_ready got=%b exp=1", bus.io_in_ready); end
    repeat (2) @(negedge clock);
    bus.io_in_valid = 1'b0;
    reset = 1'b1;
    stale = 0;
    repeat (8) begin
      @(negedge clock);
      if (bus.io_out_valid === 1'b1) stale++;
    end
    nvec++; if (stale != 0) begin nfail++; $display("FAIL rst_mid_stale got=%0d exp=0", stale); end
    run_one(32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, s, c, o, lat);
    nvec++; if (lat != LAT) begin nfail++; $display("FAIL rst_mid_latency got=%0d exp=%0d", lat, LAT); end
    nvec++; if (s !== 32'h0000_0007) begin nfail++; $display("FAIL rst_mid_sum_after got=%h exp=00000007", s); end
  endtask

  initial begin
    bus.io_in_valid = 1'b0; bus.io_out_ready = 1'b1;
    bus.io_A = '0; bus.io_B = '0; bus.io_Cin = 1'b0; bus.io_Sub = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_backpressure();
`ifdef PIPELINED_ADDER_OVERFLOW_EN
    test_overflow();
`endif
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "simulation time limit exceeded");
  end

endmodule
